// File: rtl/amm_burst_mem.sv
// Avalon-MM burst slave RAM: byte-enabled writes, one beat/word per cycle, READ_LATENCY-cycle read return.
// waitrequest is high only while a read burst is issuing; write bursts stall on write=0.
module amm_burst_mem #(
   parameter int DATA_W       = 16,
   parameter int MEM_DEPTH    = 1024,
   parameter int READ_LATENCY = 1,
   parameter int MAX_BURST    = 8,
   localparam int ADDR_W      = $clog2(MEM_DEPTH),
   localparam int BURST_W     = $clog2(MAX_BURST) + 1,
   localparam int BE_W        = DATA_W / 8
) (
   input  logic               rst_i,
   input  logic               clk_i,
   input  logic [ADDR_W-1:0]  address,
   input  logic               read,
   input  logic               write,
   input  logic [DATA_W-1:0]  writedata,
   input  logic [BE_W-1:0]    byteenable,
   input  logic [BURST_W-1:0] burstcount,
   output logic               waitrequest,
   output logic [DATA_W-1:0]  readdata,
   output logic               readdatavalid
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_BURST = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [BURST_W-1:0]   cnt_q, cnt_d;
   logic [BURST_W-1:0]   eff_len;
   logic                 wr_en, rd_en;
   logic [ADDR_W-1:0]    wr_addr, rd_addr;

   logic [DATA_W-1:0]    mem [MEM_DEPTH];

   logic                 pipe_vld_q [READ_LATENCY];
   logic                 pipe_vld_d [READ_LATENCY];
   logic [DATA_W-1:0]    pipe_dat_q [READ_LATENCY];
   logic [DATA_W-1:0]    pipe_dat_d [READ_LATENCY];

   always_comb begin
      if (burstcount == '0) begin
         eff_len = BURST_W'(1);
      end else if (burstcount > BURST_W'(MAX_BURST)) begin
         eff_len = BURST_W'(MAX_BURST);
      end else begin
         eff_len = burstcount;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_addr = address;
      rd_addr = address;
      case (state_q)
         IDLE: begin
            // write wins over a simultaneous read; that read is dropped
            if (write) begin
               wr_en = 1'b1;
               if (eff_len > BURST_W'(1)) begin
                  addr_d  = address + 1'b1;
                  cnt_d   = eff_len - 1'b1;
                  state_d = WR_BURST;
               end
            end else if (read) begin
               rd_en = 1'b1;
               if (eff_len > BURST_W'(1)) begin
                  addr_d  = address + 1'b1;
                  cnt_d   = eff_len - 1'b1;
                  state_d = RD_BURST;
               end
            end
         end
         WR_BURST: begin
            wr_addr = addr_q;
            if (write) begin
               wr_en  = 1'b1;
               addr_d = addr_q + 1'b1;
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == BURST_W'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         RD_BURST: begin
            rd_addr = addr_q;
            rd_en   = 1'b1;
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == BURST_W'(1)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Each stage only reloads when its input is valid, so readdata holds between returns.
   always_comb begin
      pipe_vld_d[0] = rd_en;
      pipe_dat_d[0] = rd_en ? mem[rd_addr] : pipe_dat_q[0];
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_dat_d[i] = pipe_vld_q[i-1] ? pipe_dat_q[i-1] : pipe_dat_q[i];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_vld_q[i] <= 1'b0;
            pipe_dat_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_vld_q[i] <= pipe_vld_d[i];
            pipe_dat_q[i] <= pipe_dat_d[i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < BE_W; b++) begin
            if (byteenable[b]) begin
               mem[wr_addr][8*b +: 8] <= writedata[8*b +: 8];
            end
         end
      end
   end

   assign waitrequest   = (state_q == RD_BURST);
   assign readdata      = pipe_dat_q[READ_LATENCY-1];
   assign readdatavalid = pipe_vld_q[READ_LATENCY-1];

endmodule

// File: doc/amm_burst_mem.md
Name: amm_burst_mem

Overview:
- Parametrised Avalon-MM slave memory: configurable data width, depth and read latency, with byteenable and burst support.
- Used as on-chip target RAM behind the JTAG-to-AMM master and as a bench memory model.
- Read bursts issue one word per cycle into a fixed-latency return pipeline. Write bursts accept one beat per cycle.

Parameters:
- DATA_W, 16, data width in bits; multiple of 8.
- MEM_DEPTH, 1024, number of DATA_W-bit words; power of 2, >= 2.
- READ_LATENCY, 1, cycles from read issue to readdatavalid; range 1..4.
- MAX_BURST, 8, largest burst length in words; power of 2, >= 1.

Ports:
- rst_i  in  1  asynchronous reset, active-high.
- clk_i  in  1  clock; all logic on the rising edge.
- address  in  ADDR_W=$clog2(MEM_DEPTH)  word address.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_W  write data.
- byteenable  in  DATA_W/8  per-byte write enable; ignored for reads.
- burstcount  in  BURST_W=$clog2(MAX_BURST)+1  burst length; sampled on the first beat only.
- waitrequest  out  1  slave busy; command not accepted while high.
- readdata  out  DATA_W  read data.
- readdatavalid  out  1  readdata valid this cycle.

Behaviour:
- Reset is rst_i, asynchronous, active-high; clock is clk_i. All sequential logic resets asynchronously.
- Reset values: state=IDLE, waitrequest=0, readdatavalid=0, readdata=0, latency pipeline cleared. Memory contents are not reset.
- Effective burst length L: burstcount=0 is treated as 1; burstcount>MAX_BURST is clamped to MAX_BURST.
- Addresses within a burst are address+k, k=0..L-1, modulo MEM_DEPTH (wrap from MEM_DEPTH-1 to 0).
- FSM states IDLE, WR_BURST, RD_BURST. waitrequest=1 only in RD_BURST; combinationally decoded from state.
- IDLE, write=1: beat 0 is written this cycle.
  - If L>1, latch next address and remaining count L-1, then go to WR_BURST. Otherwise stay in IDLE.
  - write has priority when read and write are both high; that read is ignored (protocol violation, never serviced).
- IDLE, read=1 (write=0): word at address is issued this cycle.
  - If L>1, latch next address and remaining count L-1, then go to RD_BURST. Otherwise stay in IDLE.
- WR_BURST: each cycle with write=1 writes writedata at the current address, increments the address and decrements the count.
  - Cycles with write=0 are stalls; no state change.
  - Leave to IDLE in the same cycle the last beat is written. read asserted in WR_BURST is ignored.
- RD_BURST: one word is issued per cycle, unconditionally. Return to IDLE in the cycle the last word is issued. read/write inputs are ignored.
- Write: for each byte b with byteenable[b]=1, mem[a][8b+7:8b] <= writedata[8b+7:8b]. Other bytes keep their value.
- Read issue: the memory array is sampled in the issue cycle, into pipeline stage 1.
  - Stage READ_LATENCY drives readdata/readdatavalid, so the first readdatavalid is READ_LATENCY cycles after the accept edge.
  - A write accepted the cycle after a read issue to the same address does not affect the already-issued word (old data returned).
- Back-to-back bursts: a new command may be accepted the cycle after RD_BURST exits while earlier data is still in the pipeline. Return order is always issue order; no bubbles are inserted.
- readdata holds its last valid value while readdatavalid=0.
- Reset mid-burst: the burst is aborted, the pipeline is flushed, no further readdatavalid is produced, and the FSM is in IDLE after reset release.

Test Plan:
- Single read and write (DATA_W=16, READ_LATENCY=1): write 0xBEEF to addr 5, then read addr 5 -> readdatavalid one cycle later with readdata=0xBEEF; waitrequest stays 0.
- Byteenable: write 0x1234 to addr 3, then write 0xABCD with byteenable=2'b01 -> a read returns 0x12CD.
- Read burst with wrap (MEM_DEPTH=16, READ_LATENCY=3): preload mem[i]=i, read addr 14 with burstcount 4.
  - waitrequest high for 3 cycles.
  - Four consecutive readdatavalid returning 14, 15, 0, 1; the first arrives 3 cycles after accept.
- Write burst with stall: burstcount 3 at addr 8, data 0xA, (write=0 one cycle), 0xB, 0xC -> mem[8..10]=0xA, 0xB, 0xC; FSM back in IDLE after the third beat.
- Clamp and zero (MAX_BURST=8): read burstcount 0 -> exactly 1 valid word; read burstcount 15 -> exactly 8 valid words.
- Reset mid read burst (burstcount 8, assert rst_i after 3 issues) -> readdatavalid=0 immediately and stays 0 after release; a following single read behaves normally.
